pito_dmem_arbiter: RTL and testbench
====================================

# pito_dmem_arbiter

Two-port arbiter sharing the single-ported pito data memory between the pito core dmem port and the external SoC dmem programming port. Each cycle it grants at most one requester, drives the SRAM request, and routes the one-cycle-latency read data back to the owner. Ownership follows a round-robin policy with a bounded burst. The block sits between the core/external dmem signal groups and the dmem SRAM macro.

## Interface
- `BURST`, default 4: maximum consecutive grants to one port while the other port is waiting; legal range 1..15.
- `AW`, default width of `rv32_dmem_addr_t`: word address width.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `core_req`  in  1  core dmem request.
- `core_we`  in  1  core write enable.
- `core_be`  in  4  core byte enables (`dmem_be_t`).
- `core_addr`  in  AW  core word address.
- `core_wdata`  in  32  core write data.
- `core_gnt`  out  1  core request accepted this cycle.
- `core_rvalid`  out  1  core read data valid.
- `core_rdata`  out  32  core read data.
- `ext_req`, `ext_we`, `ext_be`, `ext_addr`, `ext_wdata`  in  1/1/4/AW/32  external port request group; same meaning as the core group.
- `ext_gnt`, `ext_rvalid`, `ext_rdata`  out  1/1/32  external port response group.
- `mem_req`, `mem_we`  out  1 each  SRAM request and write enable.
- `mem_be`  out  4  SRAM byte enables.
- `mem_addr`  out  AW  SRAM address.
- `mem_wdata`  out  32  SRAM write data.
- `mem_rdata`  in  32  SRAM read data, valid one cycle after the request.

## Operation
- Grant logic is combinational from the requests and the registered state. At most one of `core_gnt`/`ext_gnt` is high in any cycle.
- `mem_req` = `core_gnt | ext_gnt`. The `mem_we/be/addr/wdata` mux selects the granted port. When there is no grant, the mux selects the core port and `mem_req` is 0.
- A requester holds its request signals stable until it sees `gnt`. The request is consumed in the cycle where `gnt` is high.
- State registers:
  - `last`: owner of the most recent grant; 0 = core, 1 = ext.
  - `run`: count of consecutive grants to `last`, 4 bits.
  - `rd_owner`, `rd_pend`: owner and pending flag for a read issued last cycle.
- Arbitration, with only one port requesting: that port is granted.
- Arbitration, with both ports requesting:
  - If `run < BURST`, grant `last`.
  - Otherwise grant the other port.
- `run` update on each grant:
  - Same owner as `last`: `run` increments, saturating at 15.
  - Different owner: `run` loads 1.
  - No grant: `run` holds.
- Read return: a granted read (`we`=0) sets `rd_pend`=1 and `rd_owner`=granted port. In the next cycle `<owner>_rvalid`=1 and `<owner>_rdata`=`mem_rdata`. The other port's `rdata` is 0.
- Writes produce no `rvalid`.
- Back-to-back reads to alternating ports are fully pipelined. `rvalid` for the read granted in cycle N appears in cycle N+1, independent of the grant in cycle N+1.

## Timing
- Reset values: `last`=0, `run`=0, `rd_pend`=0.
  - All `gnt`, `rvalid` and `mem_req` outputs are 0 during reset.
  - `rdata` outputs are 0 during reset.
- Grant latency: 0 cycles, combinational from `req`.
- Read data latency: 1 cycle after `gnt`.
- Worst-case wait while the other port requests continuously: `BURST` cycles.
- Simultaneous requests from reset: core is granted first, because `last`=0 and `run`=0 < `BURST`.
- Reset asserted mid-read: the pending `rvalid` is dropped and is not replayed after reset.
- Request withdrawn while not yet granted: this is illegal. A bench assertion flags it, and the RTL does not guard against it.

## Configuration
- `PITO_DMEM_ARB_EXT_PRIO_EN`
  - Defined: the external port has strict priority. When both ports request, ext is always granted and the `BURST` limit is ignored. `last` and `run` still update.
  - Undefined: the round-robin/burst policy above applies.

## Test plan
- Reset, then only core reads addr 0x10 with `mem_rdata`=0xDEADBEEF → `core_gnt`=1 in cycle 0; `core_rvalid`=1 and `core_rdata`=0xDEADBEEF in cycle 1; `ext_rvalid`=0.
- Both ports request continuously with `BURST`=4 → grants in the order core×4, ext×4, core×4; `mem_req`=1 every cycle.
- Ext writes 0xCAFEF00D to addr 0x20 with be=4'b0011 → `mem_we`=1, `mem_be`=4'b0011, `mem_addr`=0x20, `mem_wdata`=0xCAFEF00D in the grant cycle; no `rvalid` follows.
- Alternating single-cycle reads core/ext/core → each `rvalid` arrives exactly one cycle after its grant and goes only to its owner; no bubbles.
- Assert `rst_n` low in the cycle after a core read grant → `core_rvalid` stays 0; after release, `last`=0 and `run`=0.
- Build with `PITO_DMEM_ARB_EXT_PRIO_EN` defined and both ports requesting for 10 cycles → `ext_gnt`=1 in all 10 cycles and `core_gnt`=0.

Source files
------------

// File: rtl/pito_dmem_arbiter.sv
// rtl/pito_dmem_arbiter.sv - round-robin/bounded-burst arbiter sharing the pito dmem SRAM between core and ext ports
// Optional PITO_DMEM_ARB_EXT_PRIO_EN: external port wins every conflict (BURST ignored).
module pito_dmem_arbiter #(
  parameter int unsigned BURST = 4,
  parameter int unsigned AW    = 10
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          core_req_i,
  input  logic          core_we_i,
  input  logic [3:0]    core_be_i,
  input  logic [AW-1:0] core_addr_i,
  input  logic [31:0]   core_wdata_i,
  output logic          core_gnt_o,
  output logic          core_rvalid_o,
  output logic [31:0]   core_rdata_o,
  input  logic          ext_req_i,
  input  logic          ext_we_i,
  input  logic [3:0]    ext_be_i,
  input  logic [AW-1:0] ext_addr_i,
  input  logic [31:0]   ext_wdata_i,
  output logic          ext_gnt_o,
  output logic          ext_rvalid_o,
  output logic [31:0]   ext_rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [3:0]    mem_be_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i
);

  typedef enum logic {OWN_CORE = 1'b0, OWN_EXT = 1'b1} owner_e;

  owner_e     last_q, last_d, rd_owner_q, rd_owner_d, win_owner;
  logic [3:0] run_q, run_d;
  logic       rd_pend_q, rd_pend_d;
  logic       core_win, ext_win, any_win;

  always_comb begin
    core_win = 1'b0;
    ext_win  = 1'b0;
    if (core_req_i && ext_req_i) begin
`ifdef PITO_DMEM_ARB_EXT_PRIO_EN
      ext_win = 1'b1;
`else
      if (run_q < 4'(BURST)) begin
        core_win = (last_q == OWN_CORE);
        ext_win  = (last_q == OWN_EXT);
      end else begin
        core_win = (last_q == OWN_EXT);
        ext_win  = (last_q == OWN_CORE);
      end
`endif
    end else begin
      core_win = core_req_i;
      ext_win  = ext_req_i;
    end
  end

  assign any_win = core_win | ext_win;

  // Reset gates only the visible handshake; state flops are held by the async reset anyway.
  assign core_gnt_o = core_win & rst_ni;
  assign ext_gnt_o  = ext_win & rst_ni;
  assign mem_req_o  = any_win & rst_ni;

  assign mem_we_o    = ext_win ? ext_we_i    : core_we_i;
  assign mem_be_o    = ext_win ? ext_be_i    : core_be_i;
  assign mem_addr_o  = ext_win ? ext_addr_i  : core_addr_i;
  assign mem_wdata_o = ext_win ? ext_wdata_i : core_wdata_i;

  always_comb begin
    last_d     = last_q;
    run_d      = run_q;
    rd_owner_d = rd_owner_q;
    rd_pend_d  = 1'b0;
    win_owner  = ext_win ? OWN_EXT : OWN_CORE;
    if (any_win) begin
      if (win_owner != last_q) begin
        run_d = 4'd1;
      end else if (run_q != 4'hF) begin
        run_d = run_q + 4'd1;
      end
      last_d     = win_owner;
      rd_pend_d  = ~mem_we_o;
      rd_owner_d = win_owner;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q     <= OWN_CORE;
      run_q      <= 4'd0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= OWN_CORE;
    end else begin
      last_q     <= last_d;
      run_q      <= run_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // SRAM data is steered to whoever issued last cycle's read; the other port sees zero.
  assign core_rvalid_o = rd_pend_q && (rd_owner_q == OWN_CORE);
  assign ext_rvalid_o  = rd_pend_q && (rd_owner_q == OWN_EXT);
  assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : 32'd0;
  assign ext_rdata_o   = ext_rvalid_o  ? mem_rdata_i : 32'd0;

endmodule

// File: tb/tb_pito_dmem_arbiter.sv
// tb/tb_pito_dmem_arbiter.sv - directed vector bench for pito_dmem_arbiter
// Optional PITO_DMEM_ARB_EXT_PRIO_EN switches the conflict expectations to ext priority.
module tb_pito_dmem_arbiter;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          core_req, core_we, ext_req, ext_we;
  logic [3:0]    core_be, ext_be;
  logic [AW-1:0] core_addr, ext_addr;
  logic [31:0]   core_wdata, ext_wdata, mem_rdata;
  logic          core_gnt, core_rvalid, ext_gnt, ext_rvalid;
  logic [31:0]   core_rdata, ext_rdata;
  logic          mem_req, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  int checks = 0;
  int errors = 0;

  pito_dmem_arbiter #(.BURST(4), .AW(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_be_i(core_be),
    .core_addr_i(core_addr), .core_wdata_i(core_wdata),
    .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
    .ext_req_i(ext_req), .ext_we_i(ext_we), .ext_be_i(ext_be),
    .ext_addr_i(ext_addr), .ext_wdata_i(ext_wdata),
    .ext_gnt_o(ext_gnt), .ext_rvalid_o(ext_rvalid), .ext_rdata_o(ext_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic c_req, c_we; logic [3:0] c_be; logic [AW-1:0] c_addr; logic [31:0] c_wdata;
    logic e_req, e_we; logic [3:0] e_be; logic [AW-1:0] e_addr; logic [31:0] e_wdata;
    logic [31:0] m_rdata;
    logic [1:0] x_gnt; logic [1:0] x_rv;
    logic [31:0] x_crdata, x_erdata;
    logic x_we; logic [3:0] x_be; logic [AW-1:0] x_addr; logic [31:0] x_wdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic cr, input logic cw, input logic [3:0] cb, input logic [AW-1:0] ca, input logic [31:0] cd,
    input logic er, input logic ew, input logic [3:0] eb, input logic [AW-1:0] ea, input logic [31:0] ed,
    input logic [31:0] mr, input logic [1:0] xg, input logic [1:0] xv,
    input logic [31:0] xc, input logic [31:0] xe,
    input logic xw, input logic [3:0] xb, input logic [AW-1:0] xa, input logic [31:0] xd);
    vec_t v;
    v.c_req = cr; v.c_we = cw; v.c_be = cb; v.c_addr = ca; v.c_wdata = cd;
    v.e_req = er; v.e_we = ew; v.e_be = eb; v.e_addr = ea; v.e_wdata = ed;
    v.m_rdata = mr; v.x_gnt = xg; v.x_rv = xv; v.x_crdata = xc; v.x_erdata = xe;
    v.x_we = xw; v.x_be = xb; v.x_addr = xa; v.x_wdata = xd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    core_req = 0; core_we = 0; core_be = 4'hF; core_addr = '0; core_wdata = '0;
    ext_req = 0; ext_we = 0; ext_be = 4'h0; ext_addr = '0; ext_wdata = '0;
  endtask

  // A waiting requester must keep its request up until granted.
  logic core_wait = 1'b0;
  logic ext_wait = 1'b0;
  always @(posedge clk) begin
    if (rst_n && core_wait) begin
      checks++;
      if (!core_req) begin errors++; $display("FAIL req_hold_core: got withdraw expected hold"); end
    end
    if (rst_n && ext_wait) begin
      checks++;
      if (!ext_req) begin errors++; $display("FAIL req_hold_ext: got withdraw expected hold"); end
    end
    core_wait <= rst_n && core_req && !core_gnt;
    ext_wait  <= rst_n && ext_req && !ext_gnt;
  end

  initial begin
    logic exp_ext, prev_ext;
    vec_t v;

    // Idle core fields keep be=F so the no-grant mux expectation is the core group.
    vecs.push_back(mk(1,0,4'hF,10'h010,0,            0,0,0,0,0,                 32'h0,        2'b01,2'b00,0,0,                 0,4'hF,10'h010,0));
    vecs.push_back(mk(0,0,4'hF,0,0,                  0,0,0,0,0,                 32'hDEADBEEF, 2'b00,2'b01,32'hDEADBEEF,0,      0,4'hF,0,0));
    vecs.push_back(mk(0,0,4'hF,0,0,                  1,1,4'h3,10'h020,32'hCAFEF00D, 32'h55,   2'b10,2'b00,0,0,                 1,4'h3,10'h020,32'hCAFEF00D));
    vecs.push_back(mk(0,0,4'hF,0,0,                  0,0,0,0,0,                 32'h12345678, 2'b00,2'b00,0,0,                 0,4'hF,0,0));
    vecs.push_back(mk(1,0,4'hF,10'h001,0,            0,0,0,0,0,                 32'h0,        2'b01,2'b00,0,0,                 0,4'hF,10'h001,0));
    vecs.push_back(mk(0,0,4'hF,0,0,                  1,0,4'hF,10'h002,0,        32'hA1,       2'b10,2'b01,32'hA1,0,            0,4'hF,10'h002,0));
    vecs.push_back(mk(1,0,4'hF,10'h003,0,            0,0,0,0,0,                 32'hB2,       2'b01,2'b10,0,32'hB2,            0,4'hF,10'h003,0));
    vecs.push_back(mk(0,0,4'hF,0,0,                  0,0,0,0,0,                 32'hC3,       2'b00,2'b01,32'hC3,0,            0,4'hF,0,0));
    vecs.push_back(mk(1,1,4'h5,10'h007,32'h0BADF00D, 0,0,0,0,0,                 32'h0,        2'b01,2'b00,0,0,                 1,4'h5,10'h007,32'h0BADF00D));
    vecs.push_back(mk(0,0,4'hF,0,0,                  0,0,0,0,0,                 32'h77,       2'b00,2'b00,0,0,                 0,4'hF,0,0));

    // Reset with both requests up: nothing may leak out.
    drive_idle();
    rst_n = 0; core_req = 1; ext_req = 1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("rst_core_gnt", 32'(core_gnt), 0);
    check("rst_ext_gnt", 32'(ext_gnt), 0);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_core_rvalid", 32'(core_rvalid), 0);
    check("rst_ext_rvalid", 32'(ext_rvalid), 0);
    check("rst_core_rdata", core_rdata, 0);
    check("rst_ext_rdata", ext_rdata, 0);
    @(posedge clk); #1;
    rst_n = 1; drive_idle();

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      core_req = v.c_req; core_we = v.c_we; core_be = v.c_be; core_addr = v.c_addr; core_wdata = v.c_wdata;
      ext_req = v.e_req; ext_we = v.e_we; ext_be = v.e_be; ext_addr = v.e_addr; ext_wdata = v.e_wdata;
      mem_rdata = v.m_rdata;
      @(negedge clk);
      check($sformatf("vec%0d_gnt", i), 32'({ext_gnt, core_gnt}), 32'(v.x_gnt));
      check($sformatf("vec%0d_rvalid", i), 32'({ext_rvalid, core_rvalid}), 32'(v.x_rv));
      check($sformatf("vec%0d_core_rdata", i), core_rdata, v.x_crdata);
      check($sformatf("vec%0d_ext_rdata", i), ext_rdata, v.x_erdata);
      check($sformatf("vec%0d_mem_req", i), 32'(mem_req), 32'(|v.x_gnt));
      check($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(v.x_we));
      check($sformatf("vec%0d_mem_be", i), 32'(mem_be), 32'(v.x_be));
      check($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(v.x_addr));
      check($sformatf("vec%0d_mem_wdata", i), mem_wdata, v.x_wdata);
      @(posedge clk); #1;
    end

    // Reset arrives while a core read is in flight: its rvalid must vanish for good.
    drive_idle();
    core_req = 1; core_addr = 10'h030;
    @(negedge clk);
    check("midrst_gnt", 32'(core_gnt), 1);
    @(posedge clk); #1;
    rst_n = 0; core_req = 0; ext_req = 1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("midrst_core_rvalid", 32'(core_rvalid), 0);
    check("midrst_core_rdata", core_rdata, 0);
    check("midrst_ext_gnt", 32'(ext_gnt), 0);
    check("midrst_mem_req", 32'(mem_req), 0);
    @(posedge clk); #1;
    rst_n = 1; ext_req = 0;
    @(negedge clk);
    check("midrst_no_replay", 32'(core_rvalid), 0);
    @(posedge clk); #1;

    // Continuous conflict from freshly reset state: core x4, ext x4, core x4.
    core_req = 1; ext_req = 1; core_addr = 10'h00A; ext_addr = 10'h00B;
    prev_ext = 0;
    for (int i = 0; i < 12; i++) begin
      mem_rdata = 32'h100 + i;
`ifdef PITO_DMEM_ARB_EXT_PRIO_EN
      exp_ext = 1'b1;
`else
      exp_ext = (i >= 4 && i < 8);
`endif
      @(negedge clk);
      check($sformatf("burst%0d_core_gnt", i), 32'(core_gnt), 32'(!exp_ext));
      check($sformatf("burst%0d_ext_gnt", i), 32'(ext_gnt), 32'(exp_ext));
      check($sformatf("burst%0d_mem_req", i), 32'(mem_req), 1);
      check($sformatf("burst%0d_mem_addr", i), 32'(mem_addr), exp_ext ? 32'h00B : 32'h00A);
      if (i > 0) begin
        check($sformatf("burst%0d_core_rvalid", i), 32'(core_rvalid), 32'(!prev_ext));
        check($sformatf("burst%0d_ext_rvalid", i), 32'(ext_rvalid), 32'(prev_ext));
        check($sformatf("burst%0d_rdata", i), prev_ext ? ext_rdata : core_rdata, 32'h100 + i);
      end
      prev_ext = exp_ext;
      @(posedge clk); #1;
    end

    // The starved port is served once the other one drops out.
`ifdef PITO_DMEM_ARB_EXT_PRIO_EN
    ext_req = 0;
    @(negedge clk);
    check("tail_core_gnt", 32'(core_gnt), 1);
`else
    core_req = 0;
    @(negedge clk);
    check("tail_ext_gnt", 32'(ext_gnt), 1);
`endif
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check("tail_mem_req", 32'(mem_req), 0);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
